// File: rtl/dmem_line_responder.sv
// Fixed-latency line-memory responder for the cpu cyc/stb/resp/retry bus, backed by a line-wide array.
// Optional feature macro DMEM_RETRY_EN: every RETRY_N-th accepted request ends in mem_retry with no side effects.
module dmem_line_responder #(
   parameter int DATA_W  = 128,
   parameter int ADDR_W  = 16,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 3,
   parameter int RETRY_N = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mem_cyc,
   input  logic                mem_stb,
   input  logic                mem_write,
   input  logic [ADDR_W-1:0]   mem_address,
   input  logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W/8-1:0] mem_wmask,
   output logic [DATA_W-1:0]   mem_rdata,
   output logic                mem_resp,
   output logic                mem_retry,
   output logic                busy
);
   localparam int NBYTES = DATA_W / 8;
   localparam int OFF    = $clog2(NBYTES);
   localparam int IDX_W  = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              write_q, write_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [NBYTES-1:0] wmask_q, wmask_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              retry_q, retry_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              accept;
   logic              enter_resp;
   logic              retry_now;
   logic              commit;
   logic [DATA_W-1:0] line_old, line_new;
   logic              unused_addr;

   assign accept      = (state_q == S_IDLE) && mem_cyc && mem_stb;
   assign unused_addr = ^mem_address;

`ifdef DMEM_RETRY_EN
   logic [7:0] rcnt_q, rcnt_d, rcnt_inc;

   // Aborted transactions were accepted, so they advance the counter too.
   always_comb begin
      rcnt_inc  = rcnt_q + 8'd1;
      retry_now = (rcnt_inc == 8'(RETRY_N));
      rcnt_d    = rcnt_q;
      if (accept) rcnt_d = retry_now ? 8'd0 : rcnt_inc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rcnt_q <= '0;
      else     rcnt_q <= rcnt_d;
   end
`else
   logic [7:0] unused_retry_n;
   assign unused_retry_n = 8'(RETRY_N);
   assign retry_now      = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         write_q <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         rdata_q <= '0;
         retry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         rdata_q <= rdata_d;
         retry_q <= retry_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      enter_resp = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               cnt_d = 4'(LATENCY - 1);
               if (LATENCY == 1) begin
                  state_d    = S_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!mem_cyc) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == 4'd0) begin
               state_d    = S_RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // The _d request fields are the live request at acceptance and the latched one afterwards,
   // so the commit path works the same whether RESP follows IDLE or WAIT.
   always_comb begin
      write_d = write_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      retry_d = retry_q;
      if (accept) begin
         write_d = mem_write;
         idx_d   = mem_address[OFF+IDX_W-1:OFF];
         wdata_d = mem_wdata;
         wmask_d = mem_wmask;
         retry_d = retry_now;
      end
      line_old = mem_q[idx_d];
      line_new = line_old;
      for (int i = 0; i < NBYTES; i++) begin
         if (write_d && wmask_d[i]) line_new[i*8 +: 8] = wdata_d[i*8 +: 8];
      end
      commit  = enter_resp && !retry_d && !rst;
      rdata_d = commit ? line_new : rdata_q;
   end

   always_ff @(posedge clk) begin
      if (commit && write_d) mem_q[idx_d] <= line_new;
   end

   always_comb begin
      mem_resp  = (state_q == S_RESP) && !retry_q;
      mem_retry = (state_q == S_RESP) && retry_q;
      busy      = (state_q != S_IDLE);
   end

   assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed bench for dmem_line_responder: latency, byte masks, aliasing, abort, reset and back-to-back.
// Built with DMEM_RETRY_EN it runs the retry scenario instead of the plain data-path scenarios.
module tb_dmem_line_responder;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         mem_cyc = 1'b0;
   logic         mem_stb = 1'b0;
   logic         mem_write = 1'b0;
   logic [15:0]  mem_address = '0;
   logic [127:0] mem_wdata = '0;
   logic [15:0]  mem_wmask = '0;
   logic [127:0] mem_rdata;
   logic         mem_resp;
   logic         mem_retry;
   logic         busy;

   int errors = 0;
   int checks = 0;

   localparam logic [127:0] D1 = 128'hdeadbeef_cafef00d_01234567_00112233;
   localparam logic [127:0] L5 = 128'h55555555_aaaaaaaa_0f0f0f0f_12345678;

   dmem_line_responder dut (
      .clk(clk), .rst(rst), .mem_cyc(mem_cyc), .mem_stb(mem_stb), .mem_write(mem_write),
      .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp), .mem_retry(mem_retry), .busy(busy)
   );

   always #5 clk = ~clk;

   // Completion pulses must be single-cycle and never both at once.
   logic prev_pulse = 1'b0;
   always @(negedge clk) begin
      if (mem_resp || mem_retry) begin
         checks++;
         if ((mem_resp && mem_retry) || prev_pulse) begin
            errors++;
            $display("FAIL pulse_shape: resp=%b retry=%b prev=%b, need single one-cycle pulse", mem_resp, mem_retry, prev_pulse);
         end
      end
      prev_pulse = mem_resp || mem_retry;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One request, stb dropped after acceptance, cyc held until completion.
   task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [127:0] wd,
                          input logic [15:0] wm, output int lat, output logic [127:0] rd, output logic rty);
      @(negedge clk);
      mem_cyc = 1'b1; mem_stb = 1'b1; mem_write = wr;
      mem_address = addr; mem_wdata = wd; mem_wmask = wm;
      @(negedge clk);
      mem_stb = 1'b0;
      lat = -1; rd = '0; rty = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (mem_resp || mem_retry) begin
            lat = k; rd = mem_rdata; rty = mem_retry;
            break;
         end
      end
      mem_cyc = 1'b0;
   endtask

   task automatic test_reset();
      int lat; logic [127:0] rd; logic rty; logic saw;
      @(negedge clk);
      checks++; if (mem_resp !== 1'b0) begin errors++; $display("FAIL rst_resp: got %b want 0", mem_resp); end
      checks++; if (mem_retry !== 1'b0) begin errors++; $display("FAIL rst_retry: got %b want 0", mem_retry); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (mem_rdata !== 128'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", mem_rdata); end
      rst = 1'b0;
      run_txn(1'b1, 16'h0050, L5, 16'hffff, lat, rd, rty);
      checks++; if (lat !== 3) begin errors++; $display("FAIL rst_prep_lat: got %0d want 3", lat); end
      // Pending write to line 5, reset lands in WAIT.
      @(negedge clk);
      mem_cyc = 1'b1; mem_stb = 1'b1; mem_write = 1'b1;
      mem_address = 16'h0050; mem_wdata = ~L5; mem_wmask = 16'hffff;
      @(negedge clk);
      mem_stb = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (mem_resp !== 1'b0) begin errors++; $display("FAIL midrst_resp: got %b want 0", mem_resp); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
      checks++; if (mem_rdata !== 128'h0) begin errors++; $display("FAIL midrst_rdata: got %h want 0", mem_rdata); end
      rst = 1'b0; mem_cyc = 1'b0;
      saw = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (mem_resp || mem_retry) saw = 1'b1;
      end
      checks++; if (saw !== 1'b0) begin errors++; $display("FAIL midrst_noresp: got %b want 0", saw); end
      run_txn(1'b0, 16'h0050, '0, 16'h0, lat, rd, rty);
      checks++; if (lat !== 3) begin errors++; $display("FAIL rst_read_lat: got %0d want 3", lat); end
      checks++; if (rd !== L5) begin errors++; $display("FAIL rst_read_old: got %h want %h", rd, L5); end
   endtask

   task automatic test_write_read();
      int lat; logic [127:0] rd; logic rty;
      run_txn(1'b1, 16'h0040, D1, 16'hffff, lat, rd, rty);
      checks++; if (lat !== 3) begin errors++; $display("FAIL wr_lat: got %0d want 3", lat); end
      checks++; if (rd !== D1) begin errors++; $display("FAIL wr_rdata: got %h want %h", rd, D1); end
      checks++; if (rty !== 1'b0) begin errors++; $display("FAIL wr_retry: got %b want 0", rty); end
      run_txn(1'b0, 16'h0040, '0, 16'h0, lat, rd, rty);
      checks++; if (lat !== 3) begin errors++; $display("FAIL rd_lat: got %0d want 3", lat); end
      checks++; if (rd !== D1) begin errors++; $display("FAIL rd_data: got %h want %h", rd, D1); end
   endtask

   task automatic test_byte_mask();
      int lat; logic [127:0] rd; logic rty;
      logic [127:0] exp2;
      exp2 = {8'hab, 104'h0, 16'hffff};
      run_txn(1'b1, 16'h0100, '0, 16'hffff, lat, rd, rty);
      checks++; if (rd !== 128'h0) begin errors++; $display("FAIL mask_zero: got %h want 0", rd); end
      run_txn(1'b1, 16'h0100, {16{8'hff}}, 16'h0003, lat, rd, rty);
      checks++; if (rd !== 128'hffff) begin errors++; $display("FAIL mask_wr3: got %h want ffff", rd); end
      run_txn(1'b0, 16'h0100, '0, 16'hffff, lat, rd, rty);
      checks++; if (rd !== 128'hffff) begin errors++; $display("FAIL mask_rd3: got %h want ffff", rd); end
      run_txn(1'b1, 16'h0100, {16{8'hab}}, 16'h8000, lat, rd, rty);
      checks++; if (rd !== exp2) begin errors++; $display("FAIL mask_top: got %h want %h", rd, exp2); end
      run_txn(1'b1, 16'h0100, {16{8'h55}}, 16'h0000, lat, rd, rty);
      checks++; if (lat !== 3) begin errors++; $display("FAIL mask_none_lat: got %0d want 3", lat); end
      checks++; if (rd !== exp2) begin errors++; $display("FAIL mask_none_wr: got %h want %h", rd, exp2); end
      run_txn(1'b0, 16'h0100, '0, 16'h0, lat, rd, rty);
      checks++; if (rd !== exp2) begin errors++; $display("FAIL mask_none_rd: got %h want %h", rd, exp2); end
   endtask

   task automatic test_alias();
      int lat; logic [127:0] rd; logic rty;
      run_txn(1'b0, 16'h1040, '0, 16'h0, lat, rd, rty);
      checks++; if (rd !== D1) begin errors++; $display("FAIL alias_hi: got %h want %h", rd, D1); end
      run_txn(1'b0, 16'h004f, '0, 16'h0, lat, rd, rty);
      checks++; if (rd !== D1) begin errors++; $display("FAIL alias_off: got %h want %h", rd, D1); end
      run_txn(1'b0, 16'hf047, '0, 16'h0, lat, rd, rty);
      checks++; if (rd !== D1) begin errors++; $display("FAIL alias_both: got %h want %h", rd, D1); end
   endtask

   task automatic test_abort();
      int lat; logic [127:0] rd; logic rty; logic saw;
      @(negedge clk);
      mem_cyc = 1'b1; mem_stb = 1'b1; mem_write = 1'b1;
      mem_address = 16'h0040; mem_wdata = {16{8'h77}}; mem_wmask = 16'hffff;
      @(negedge clk);
      mem_stb = 1'b0;
      @(negedge clk);
      mem_cyc = 1'b0;
      saw = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (mem_resp || mem_retry) saw = 1'b1;
      end
      checks++; if (saw !== 1'b0) begin errors++; $display("FAIL abort_noresp: got %b want 0", saw); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
      run_txn(1'b0, 16'h0040, '0, 16'h0, lat, rd, rty);
      checks++; if (lat !== 3) begin errors++; $display("FAIL abort_next_lat: got %0d want 3", lat); end
      checks++; if (rd !== D1) begin errors++; $display("FAIL abort_nowrite: got %h want %h", rd, D1); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] resp_seen;
      logic [127:0] rd2;
      logic busy4;
      logic [127:0] exp_line;
      exp_line = {8'hab, 104'h0, 16'hffff};
      resp_seen = '0; rd2 = '0; busy4 = 1'b1;
      @(negedge clk);
      mem_cyc = 1'b1; mem_stb = 1'b1; mem_write = 1'b0;
      mem_address = 16'h0100; mem_wmask = 16'h0;
      @(negedge clk);
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (mem_resp) resp_seen[k] = 1'b1;
         if (k == 4) busy4 = busy;
         if (k == 8) rd2 = mem_rdata;
      end
      mem_cyc = 1'b0; mem_stb = 1'b0;
      checks++; if (resp_seen !== 16'h0108) begin errors++; $display("FAIL b2b_timing: got %h want 0108", resp_seen); end
      checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got %b want 0", busy4); end
      checks++; if (rd2 !== exp_line) begin errors++; $display("FAIL b2b_rdata: got %h want %h", rd2, exp_line); end
      @(negedge clk);
   endtask

`ifdef DMEM_RETRY_EN
   task automatic test_retry();
      int lat; logic [127:0] rd; logic rty;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      run_txn(1'b1, 16'h0070, '0, 16'hffff, lat, rd, rty);
      checks++; if (rty !== 1'b0) begin errors++; $display("FAIL retry_acc1: got %b want 0", rty); end
      run_txn(1'b1, 16'h0070, 128'h11, 16'h0001, lat, rd, rty);
      checks++; if (rd !== 128'h11) begin errors++; $display("FAIL retry_acc2: got %h want 11", rd); end
      run_txn(1'b1, 16'h0070, 128'h22, 16'h0001, lat, rd, rty);
      checks++; if (rd !== 128'h22) begin errors++; $display("FAIL retry_acc3: got %h want 22", rd); end
      run_txn(1'b1, 16'h0070, 128'haa, 16'h0001, lat, rd, rty);
      checks++; if (rty !== 1'b1) begin errors++; $display("FAIL retry_pulse: got %b want 1", rty); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL retry_lat: got %0d want 3", lat); end
      checks++; if (rd !== 128'h22) begin errors++; $display("FAIL retry_rdata_held: got %h want 22", rd); end
      run_txn(1'b0, 16'h0070, '0, 16'h0, lat, rd, rty);
      checks++; if (rd !== 128'h22) begin errors++; $display("FAIL retry_nowrite: got %h want 22", rd); end
      run_txn(1'b1, 16'h0070, 128'haa, 16'h0001, lat, rd, rty);
      checks++; if (rty !== 1'b0) begin errors++; $display("FAIL reissue_resp: got %b want 0", rty); end
      checks++; if (rd !== 128'haa) begin errors++; $display("FAIL reissue_data: got %h want aa", rd); end
   endtask
`endif

   initial begin
      test_reset();
`ifdef DMEM_RETRY_EN
      test_retry();
`else
      test_write_read();
      test_byte_mask();
      test_alias();
      test_abort();
      test_back_to_back();
`endif
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
